code_pulse_generator: RTL and testbench
=======================================

Name: code_pulse_generator

Overview:
- Downstream of the transceiver sequencer; consumes GEN, CODE, CODE_LEN, CODE_DURATION and PULSE_LEN.
- On each GEN request, emits one phase-coded RF pulse: an RF gate plus a per-chip phase bit to the AD9911 BPSK profile pin.
- Returns the SIGNAL_GEN_OVER level handshake that the sequencer waits on before advancing to the next code.

Parameters:
- MAX_CHIPS, 32, maximum chips per code word (CODE width).
- CNT_W, 16, width of the chip-duration and window counters.
- RF_LEAD, 2, cycles PULSE_EN is asserted before chip 0 (RF switch settling).

Ports:
- CLOCK_10M  in  1  system clock.
- RESET  in  1  asynchronous active-high reset.
- GEN  in  1  level request from the sequencer; held high until SIGNAL_GEN_OVER is seen.
- CODE  in  32  chip pattern; chip i = CODE[CODE_LEN-1-i] (MSB-first).
- CODE_LEN  in  16  number of chips.
- CODE_DURATION  in  16  clock cycles per chip.
- PULSE_LEN  in  16  total window in cycles: lead + chips + guard.
- PULSE_EN  out  1  RF gate to the switch / AD9911 output enable.
- PHASE_BIT  out  1  current chip phase (0 = 0°, 1 = 180°).
- SIGNAL_GEN_OVER  out  1  window complete; held until GEN falls.
- BUSY  out  1  high in every state except IDLE.
- TRUNC  out  1  sticky per request: chips were cut short by PULSE_LEN.
- PARAM_ERR  out  1  sticky per request: CODE_LEN = 0 or CODE_DURATION = 0.

Behaviour:
- Reset (async, RESET=1): state IDLE. All outputs 0. All counters 0.
- GEN rise detect: gen_d is registered GEN. Start condition is GEN & ~gen_d, evaluated only in IDLE. A GEN that is already high when RESET deasserts does not start a pulse until it falls and rises again.
- IDLE: on start, latch CODE, CODE_LEN clamped to MAX_CHIPS, CODE_DURATION and PULSE_LEN into shadow registers. Clear TRUNC and PARAM_ERR. Set win_cnt = 1.
  - Latched CODE_LEN = 0, or CODE_DURATION = 0, or PULSE_LEN = 0 → PARAM_ERR=1, go to DONE.
  - Otherwise go to LEAD. PULSE_EN=1 on the next cycle.
- LEAD: lasts RF_LEAD cycles with PHASE_BIT=0, then CHIP. When RF_LEAD = 0, go straight to CHIP.
- CHIP: PHASE_BIT = current chip, held CODE_DURATION cycles per chip.
  - After the last chip: PULSE_EN=0, PHASE_BIT=0, go to GUARD.
  - The first chip appears RF_LEAD+1 cycles after the cycle in which the GEN rise is sampled.
- Window counter: win_cnt increments every cycle in LEAD/CHIP/GUARD. When win_cnt reaches PULSE_LEN, enter DONE from any of those states.
  - If this happens in LEAD or CHIP: set TRUNC=1 and drop PULSE_EN the same cycle.
  - Lead + chips exactly equal to PULSE_LEN is not truncation; go to DONE with zero guard cycles.
- GUARD: PULSE_EN=0 (receive listening gap) until the window ends.
- DONE: SIGNAL_GEN_OVER=1, held while GEN=1. When GEN=0 is sampled: SIGNAL_GEN_OVER=0, go to IDLE. BUSY drops that same cycle.
- GEN falls before DONE (abort): next cycle PULSE_EN=0, PHASE_BIT=0, go to IDLE. SIGNAL_GEN_OVER is never asserted.
- Input changes after latch are ignored until the next start.
- All counters are CNT_W-bit unsigned and saturate, never wrap. PULSE_LEN = 0xFFFF is legal.
- Outputs are registered; no combinational path from any input to any output.

Optional Feature:
- Macro CODE_DIFF_ENC_EN.
- Defined: differential phase encoding. At each chip boundary PHASE_BIT toggles if the chip is 1 and holds if 0. The reference phase is 0 at the start of LEAD. The DONE/idle value is still 0.
- Undefined: PHASE_BIT equals the chip value directly.

Decomposition:
- Shared package: state encoding constants (IDLE, LEAD, CHIP, GUARD, DONE); MAX_CHIPS; CNT_W. The same constants are used by the sequencer and the receiver-window block.
- One natural sub-module: code_chip_shifter.
  - Loads CODE left-aligned by CODE_LEN.
  - Shifts one chip per CODE_DURATION tick.
  - Outputs the current chip and a last_chip flag.
  - Holds the differential-encoding register when CODE_DIFF_ENC_EN is defined.

Test Plan:
- Barker-13: CODE=0x1F35, CODE_LEN=13, CODE_DURATION=4, PULSE_LEN=100, RF_LEAD=2.
  → PULSE_EN high for 54 cycles. PHASE_BIT = 1111100110101, 4 cycles per chip. SIGNAL_GEN_OVER rises 100 cycles after start and clears one cycle after GEN falls.
- Truncation: CODE_LEN=32, CODE_DURATION=10, PULSE_LEN=50.
  → PULSE_EN drops at win_cnt=50. TRUNC=1. SIGNAL_GEN_OVER=1.
- Abort: GEN falls at chip 3 of the Barker run.
  → PULSE_EN=0 next cycle. SIGNAL_GEN_OVER stays 0. BUSY=0. A new GEN rise restarts cleanly.
- Param error: CODE_DURATION=0.
  → PULSE_EN never asserts. PARAM_ERR=1. SIGNAL_GEN_OVER=1 within 2 cycles.
- Reset mid-CHIP (RESET pulse, 1 cycle) with GEN held high.
  → All outputs 0 immediately. No restart until GEN falls and rises again.
- Back-to-back: 3 sequential GEN requests, each waiting for OVER.
  → 3 identical pulses with identical start latency. With CODE_DIFF_ENC_EN defined, CODE=0b101, LEN=3 gives PHASE_BIT 1,1,0.

Source files
------------

// File: rtl/code_pulse_generator_pkg.sv
// code_pulse_generator_pkg
//   Constants shared by the transceiver sequencer, the code pulse generator
//   and the receiver-window block: the pulse state encoding, the maximum
//   code-word length and the width of the timing counters.
//   Optional build macro used by this slice: CODE_DIFF_ENC_EN.
package code_pulse_generator_pkg;

  localparam int CPG_MAX_CHIPS = 32;
  localparam int CPG_CNT_W     = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    CHIP  = 3'd2,
    GUARD = 3'd3,
    DONE  = 3'd4
  } cpg_state_t;

endpackage

// File: rtl/code_pulse_generator_if.sv
// code_pulse_generator_if
//   Request/response bundle between the transceiver sequencer (master) and
//   the code pulse generator (slave).
//   Request : GEN (level), CODE, CODE_LEN, CODE_DURATION, PULSE_LEN
//   Response: PULSE_EN, PHASE_BIT, SIGNAL_GEN_OVER, BUSY, TRUNC, PARAM_ERR
interface code_pulse_generator_if #(
  parameter int MAX_CHIPS = code_pulse_generator_pkg::CPG_MAX_CHIPS,
  parameter int CNT_W     = code_pulse_generator_pkg::CPG_CNT_W
);

  logic                 GEN;
  logic [MAX_CHIPS-1:0] CODE;
  logic [CNT_W-1:0]     CODE_LEN;
  logic [CNT_W-1:0]     CODE_DURATION;
  logic [CNT_W-1:0]     PULSE_LEN;
  logic                 PULSE_EN;
  logic                 PHASE_BIT;
  logic                 SIGNAL_GEN_OVER;
  logic                 BUSY;
  logic                 TRUNC;
  logic                 PARAM_ERR;

  modport master (
    output GEN, CODE, CODE_LEN, CODE_DURATION, PULSE_LEN,
    input  PULSE_EN, PHASE_BIT, SIGNAL_GEN_OVER, BUSY, TRUNC, PARAM_ERR
  );

  modport slave (
    input  GEN, CODE, CODE_LEN, CODE_DURATION, PULSE_LEN,
    output PULSE_EN, PHASE_BIT, SIGNAL_GEN_OVER, BUSY, TRUNC, PARAM_ERR
  );

endinterface

// File: rtl/code_chip_shifter.sv
// code_chip_shifter
//   Holds the latched code word left-aligned so the current chip is always
//   the MSB, steps one chip per request and produces the registered phase
//   bit for the next cycle.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     load          latch code_in / len_in (start of a request)
//     code_in       raw code word, chip i = code_in[len_in-1-i]
//     len_in        chip count, already clamped to MAX_CHIPS
//     step          advance to the next chip at this edge
//     chip_start    the next cycle is the first cycle of a chip
//     out_en        the next cycle is a CHIP cycle (phase driven)
//     phase         registered phase bit (0 outside CHIP)
//     last_chip     the current chip is the final one
//   Build macro CODE_DIFF_ENC_EN: phase toggles at each chip boundary whose
//   chip is 1 instead of following the chip value directly.
module code_chip_shifter #(
  parameter int MAX_CHIPS = 32,
  parameter int LEN_W     = $clog2(MAX_CHIPS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [MAX_CHIPS-1:0] code_in,
  input  logic [LEN_W-1:0]     len_in,
  input  logic                 step,
  input  logic                 chip_start,
  input  logic                 out_en,
  output logic                 phase,
  output logic                 last_chip
);

  logic [MAX_CHIPS-1:0] sreg;
  logic [MAX_CHIPS-1:0] sreg_n;
  logic [LEN_W-1:0]     left;

  // Next shift-register content; the phase flop looks at its MSB so the
  // output lines up with the cycle the state machine enters.
  always_comb begin
    sreg_n = sreg;
    if (load) begin
      sreg_n = code_in << (LEN_W'(MAX_CHIPS) - len_in);
    end else if (step) begin
      sreg_n = sreg << 1;
    end
  end

  always_ff @(posedge clk) begin
    sreg <= sreg_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left <= '0;
    end else if (load) begin
      left <= len_in;
    end else if (step && (left != '0)) begin
      left <= left - 1'b1;
    end
  end

  assign last_chip = (left == LEN_W'(1));

`ifdef CODE_DIFF_ENC_EN
  logic ref_q;
  logic ref_n;

  // Reference phase restarts at 0 with every request and toggles on entry
  // to each chip whose value is 1.
  always_comb begin
    ref_n = load ? 1'b0 : ref_q;
    if (chip_start) begin
      ref_n = ref_n ^ sreg_n[MAX_CHIPS-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q <= 1'b0;
      phase <= 1'b0;
    end else begin
      ref_q <= ref_n;
      phase <= out_en & ref_n;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= 1'b0;
    end else begin
      phase <= out_en & sreg_n[MAX_CHIPS-1];
    end
  end
`endif

endmodule

// File: rtl/code_pulse_generator.sv
// code_pulse_generator
//   On each rising GEN request emits one phase-coded RF pulse: RF gate
//   (PULSE_EN) opened RF_LEAD cycles ahead of chip 0, one PHASE_BIT per chip
//   held CODE_DURATION cycles, then a receive guard gap until PULSE_LEN
//   window cycles have elapsed. SIGNAL_GEN_OVER is then held until GEN falls.
//   Ports:
//     CLOCK_10M   system clock
//     RESET       asynchronous active-high reset
//     bus         code_pulse_generator_if.slave (GEN, CODE, CODE_LEN,
//                 CODE_DURATION, PULSE_LEN in; PULSE_EN, PHASE_BIT,
//                 SIGNAL_GEN_OVER, BUSY, TRUNC, PARAM_ERR out)
//   Build macro CODE_DIFF_ENC_EN selects differential phase encoding
//   (see code_chip_shifter).
module code_pulse_generator
  import code_pulse_generator_pkg::*;
#(
  parameter int MAX_CHIPS = CPG_MAX_CHIPS,
  parameter int CNT_W     = CPG_CNT_W,
  parameter int RF_LEAD   = 2
) (
  input  logic CLOCK_10M,
  input  logic RESET,
  code_pulse_generator_if.slave bus
);

  localparam int               LEN_W     = $clog2(MAX_CHIPS + 1);
  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'((RF_LEAD > 0) ? RF_LEAD - 1 : 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
    return (len > CNT_W'(MAX_CHIPS)) ? LEN_W'(MAX_CHIPS) : len[LEN_W-1:0];
  endfunction

  cpg_state_t       state;
  cpg_state_t       state_n;
  logic             gen_d;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] win_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [CNT_W-1:0] dur_s;
  logic [CNT_W-1:0] plen_s;
  logic             trunc_n;
  logic             perr_n;
  logic             load;
  logic             step;
  logic             chip_start;
  logic             chip_last;
  logic             phase_bit;
  logic [LEN_W-1:0] len_cl;
  logic             start;
  logic             param_bad;
  logic             win_end;
  logic             chip_end;

  assign start     = bus.GEN & ~gen_d;
  assign len_cl    = clamp_len(bus.CODE_LEN);
  assign param_bad = (len_cl == '0) || (bus.CODE_DURATION == '0) || (bus.PULSE_LEN == '0);
  assign win_end   = (win_cnt >= plen_s);
  assign chip_end  = (cnt == dur_s - 1'b1);

  // Request shadow registers: only the chip shifter and these hold request
  // data, so later input changes cannot disturb a pulse in flight.
  always_ff @(posedge CLOCK_10M) begin
    if (load) begin
      dur_s  <= bus.CODE_DURATION;
      plen_s <= bus.PULSE_LEN;
    end
  end

  // cnt counts lead cycles in LEAD and cycles within the current chip in
  // CHIP; win_cnt is the 1-based window position.
  always_comb begin
    state_n    = state;
    win_n      = win_cnt;
    cnt_n      = cnt;
    trunc_n    = bus.TRUNC;
    perr_n     = bus.PARAM_ERR;
    load       = 1'b0;
    step       = 1'b0;
    chip_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          trunc_n = 1'b0;
          perr_n  = 1'b0;
          win_n   = CNT_W'(1);
          cnt_n   = '0;
          if (param_bad) begin
            perr_n  = 1'b1;
            state_n = DONE;
          end else if (RF_LEAD == 0) begin
            state_n    = CHIP;
            chip_start = 1'b1;
          end else begin
            state_n = LEAD;
          end
        end
      end
      LEAD: begin
        if (!bus.GEN) begin
          state_n = IDLE;
        end else if (win_end) begin
          state_n = DONE;
          trunc_n = 1'b1;
        end else begin
          win_n = sat_inc(win_cnt);
          if (cnt == LEAD_LAST) begin
            cnt_n      = '0;
            state_n    = CHIP;
            chip_start = 1'b1;
          end else begin
            cnt_n = sat_inc(cnt);
          end
        end
      end
      CHIP: begin
        if (!bus.GEN) begin
          state_n = IDLE;
        end else if (win_end) begin
          // Window closing exactly on the last chip's final cycle is a
          // complete pulse with no guard, not a truncation.
          state_n = DONE;
          trunc_n = !(chip_last && chip_end);
        end else begin
          win_n = sat_inc(win_cnt);
          if (chip_end) begin
            cnt_n = '0;
            if (chip_last) begin
              state_n = GUARD;
            end else begin
              step       = 1'b1;
              chip_start = 1'b1;
            end
          end else begin
            cnt_n = sat_inc(cnt);
          end
        end
      end
      GUARD: begin
        if (!bus.GEN) begin
          state_n = IDLE;
        end else if (win_end) begin
          state_n = DONE;
        end else begin
          win_n = sat_inc(win_cnt);
        end
      end
      DONE: begin
        if (!bus.GEN) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // All outputs are flops loaded from the next state, so each one changes
  // on the same edge as the state it describes.
  always_ff @(posedge CLOCK_10M or posedge RESET) begin
    if (RESET) begin
      state               <= IDLE;
      // A GEN already high when reset releases must fall and rise again
      // before it counts as a request.
      gen_d               <= 1'b1;
      win_cnt             <= '0;
      cnt                 <= '0;
      bus.PULSE_EN        <= 1'b0;
      bus.SIGNAL_GEN_OVER <= 1'b0;
      bus.BUSY            <= 1'b0;
      bus.TRUNC           <= 1'b0;
      bus.PARAM_ERR       <= 1'b0;
    end else begin
      state               <= state_n;
      gen_d               <= bus.GEN;
      win_cnt             <= win_n;
      cnt                 <= cnt_n;
      bus.PULSE_EN        <= (state_n == LEAD) || (state_n == CHIP);
      bus.SIGNAL_GEN_OVER <= (state_n == DONE);
      bus.BUSY            <= (state_n != IDLE);
      bus.TRUNC           <= trunc_n;
      bus.PARAM_ERR       <= perr_n;
    end
  end

  code_chip_shifter #(
    .MAX_CHIPS (MAX_CHIPS),
    .LEN_W     (LEN_W)
  ) u_shifter (
    .clk        (CLOCK_10M),
    .rst        (RESET),
    .load       (load),
    .code_in    (bus.CODE),
    .len_in     (len_cl),
    .step       (step),
    .chip_start (chip_start),
    .out_en     (state_n == CHIP),
    .phase      (phase_bit),
    .last_chip  (chip_last)
  );

  assign bus.PHASE_BIT = phase_bit;

endmodule

// File: tb/tb_code_pulse_generator.sv
// tb_code_pulse_generator
//   Self-checking bench for code_pulse_generator: reset state, a table of
//   request vectors with expected pulse summaries, hand-written multi-cycle
//   sequences (Barker phase, abort, reset with GEN held, back-to-back) and
//   randomized requests checked cycle by cycle against a window model.
//   Honours CODE_DIFF_ENC_EN when the design is built with it.
module tb_code_pulse_generator;
  import code_pulse_generator_pkg::*;

  localparam int RF_LEAD = 2;

  typedef struct {
    logic [31:0] code;
    int          len;
    int          dur;
    int          plen;
    int          exp_pe_cycles;
    int          exp_over_k;
    logic        exp_trunc;
    logic        exp_perr;
  } vec_t;

  typedef struct {
    logic pe;
    logic ph;
    logic ov;
    logic tr;
    logic pr;
  } exp_t;

  logic CLOCK_10M = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[9];

  code_pulse_generator_if bus ();

  code_pulse_generator #(
    .MAX_CHIPS (CPG_MAX_CHIPS),
    .CNT_W     (CPG_CNT_W),
    .RF_LEAD   (RF_LEAD)
  ) dut (
    .CLOCK_10M (CLOCK_10M),
    .RESET     (RESET),
    .bus       (bus)
  );

  always #5 CLOCK_10M = ~CLOCK_10M;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outputs k cycles after the edge that samples the GEN rise,
  // GEN held high throughout.
  function automatic exp_t model(input logic [31:0] code, input int len, input int dur,
                                 input int plen, input int k);
    exp_t e;
    int   lc;
    int   active;
    int   chip;
    logic acc;
    e  = '{pe: 1'b0, ph: 1'b0, ov: 1'b0, tr: 1'b0, pr: 1'b0};
    lc = (len > 32) ? 32 : len;
    if (lc == 0 || dur == 0 || plen == 0) begin
      e.pr = 1'b1;
      e.ov = 1'b1;
      return e;
    end
    active = RF_LEAD + lc * dur;
    if (k > plen) begin
      e.ov = 1'b1;
      e.tr = (active > plen);
      return e;
    end
    e.pe = (k <= active);
    if (k > RF_LEAD && k <= active) begin
      chip = (k - RF_LEAD - 1) / dur;
      acc  = 1'b0;
`ifdef CODE_DIFF_ENC_EN
      for (int i = 0; i <= chip; i++) acc = acc ^ code[lc-1-i];
`else
      acc = code[lc-1-chip];
`endif
      e.ph = acc;
    end
    return e;
  endfunction

  task automatic set_req(input logic [31:0] code, input int len, input int dur, input int plen);
    bus.CODE          = code;
    bus.CODE_LEN      = 16'(len);
    bus.CODE_DURATION = 16'(dur);
    bus.PULSE_LEN     = 16'(plen);
  endtask

  // One full request checked every cycle against the model; inputs are
  // scrambled after the latch to show they are ignored.
  task automatic run_req(input logic [31:0] code, input int len, input int dur,
                         input int plen, input string tag);
    exp_t e;
    int   n;
    set_req(code, len, dur, plen);
    bus.GEN = 1'b1;
    n = (plen == 0) ? 2 : plen + 2;
    for (int k = 1; k <= n; k++) begin
      @(negedge CLOCK_10M);
      e = model(code, len, dur, plen, k);
      chk($sformatf("%s_pe_k%0d", tag, k), 32'(bus.PULSE_EN), 32'(e.pe));
      chk($sformatf("%s_ph_k%0d", tag, k), 32'(bus.PHASE_BIT), 32'(e.ph));
      chk($sformatf("%s_over_k%0d", tag, k), 32'(bus.SIGNAL_GEN_OVER), 32'(e.ov));
      chk($sformatf("%s_busy_k%0d", tag, k), 32'(bus.BUSY), 32'd1);
      chk($sformatf("%s_trunc_k%0d", tag, k), 32'(bus.TRUNC), 32'(e.tr));
      chk($sformatf("%s_perr_k%0d", tag, k), 32'(bus.PARAM_ERR), 32'(e.pr));
      if (k == 1) set_req($urandom, int'($urandom_range(0, 34)), int'($urandom_range(0, 5)),
                          int'($urandom_range(0, 120)));
    end
    bus.GEN = 1'b0;
    @(negedge CLOCK_10M);
    chk({tag, "_over_clr"}, 32'(bus.SIGNAL_GEN_OVER), 32'd0);
    chk({tag, "_busy_clr"}, 32'(bus.BUSY), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int pe_cnt;
    int over_k;
    int lim;
    set_req(v.code, v.len, v.dur, v.plen);
    bus.GEN = 1'b1;
    pe_cnt  = 0;
    over_k  = 0;
    lim     = v.plen + 5;
    for (int k = 1; k <= lim; k++) begin
      @(negedge CLOCK_10M);
      if (bus.PULSE_EN) pe_cnt++;
      if (bus.SIGNAL_GEN_OVER && over_k == 0) over_k = k;
    end
    chk($sformatf("vec%0d_pe_cycles", idx), 32'(pe_cnt), 32'(v.exp_pe_cycles));
    chk($sformatf("vec%0d_over_k", idx), 32'(over_k), 32'(v.exp_over_k));
    chk($sformatf("vec%0d_trunc", idx), 32'(bus.TRUNC), 32'(v.exp_trunc));
    chk($sformatf("vec%0d_perr", idx), 32'(bus.PARAM_ERR), 32'(v.exp_perr));
    bus.GEN = 1'b0;
    @(negedge CLOCK_10M);
    chk($sformatf("vec%0d_over_clr", idx), 32'(bus.SIGNAL_GEN_OVER), 32'd0);
  endtask

  initial begin
    logic [12:0] bark_ph;
    logic [2:0]  b2b_ph;
    int          lat;
    int          over_k;

    vecs[0] = '{32'h0000_1F35, 13,  4, 100,  54, 101, 1'b0, 1'b0};
    vecs[1] = '{32'hA5A5_3C3C, 32, 10,  50,  50,  51, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_1F35, 13,  0, 100,   0,   1, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_1F35, 13,  4,  54,  54,  55, 1'b0, 1'b0};
    vecs[4] = '{32'hFFFF_0000, 40,  1,  40,  34,  41, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_000F,  4,  2,   0,   0,   1, 1'b0, 1'b1};
    vecs[6] = '{32'h0000_0000,  0,  3,  20,   0,   1, 1'b0, 1'b1};
    vecs[7] = '{32'h0000_000F,  4,  2,   1,   1,   2, 1'b1, 1'b0};
    vecs[8] = '{32'h0000_0001,  1,  5,   2,   2,   3, 1'b1, 1'b0};

`ifdef CODE_DIFF_ENC_EN
    bark_ph = 13'b1010111011001;
    b2b_ph  = 3'b110;
`else
    bark_ph = 13'b1111100110101;
    b2b_ph  = 3'b101;
`endif

    RESET   = 1'b1;
    bus.GEN = 1'b0;
    set_req(32'h0, 0, 0, 0);
    repeat (3) @(negedge CLOCK_10M);
    chk("rst_pe", 32'(bus.PULSE_EN), 32'd0);
    chk("rst_ph", 32'(bus.PHASE_BIT), 32'd0);
    chk("rst_over", 32'(bus.SIGNAL_GEN_OVER), 32'd0);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_trunc", 32'(bus.TRUNC), 32'd0);
    chk("rst_perr", 32'(bus.PARAM_ERR), 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLOCK_10M);
    chk("idle_busy", 32'(bus.BUSY), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Barker-13 phase pattern and OVER timing.
    set_req(32'h0000_1F35, 13, 4, 100);
    bus.GEN = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      @(negedge CLOCK_10M);
      if (k >= 3 && k <= 54 && ((k - 3) % 4) == 1)
        chk($sformatf("bark_ph_chip%0d", (k - 3) / 4), 32'(bus.PHASE_BIT),
            32'(bark_ph[12 - (k - 3) / 4]));
      if (k == 2) chk("bark_lead_ph", 32'(bus.PHASE_BIT), 32'd0);
      if (k == 55) chk("bark_guard_pe", 32'(bus.PULSE_EN), 32'd0);
      if (k == 100) chk("bark_over_k100", 32'(bus.SIGNAL_GEN_OVER), 32'd0);
      if (k == 101) chk("bark_over_k101", 32'(bus.SIGNAL_GEN_OVER), 32'd1);
    end
    repeat (3) @(negedge CLOCK_10M);
    chk("bark_over_held", 32'(bus.SIGNAL_GEN_OVER), 32'd1);
    bus.GEN = 1'b0;
    @(negedge CLOCK_10M);
    chk("bark_over_clr", 32'(bus.SIGNAL_GEN_OVER), 32'd0);
    chk("bark_busy_clr", 32'(bus.BUSY), 32'd0);

    // Abort at chip 3, then a clean restart.
    set_req(32'h0000_1F35, 13, 4, 100);
    bus.GEN = 1'b1;
    repeat (15) @(negedge CLOCK_10M);
    chk("abort_pre_pe", 32'(bus.PULSE_EN), 32'd1);
    bus.GEN = 1'b0;
    @(negedge CLOCK_10M);
    chk("abort_pe", 32'(bus.PULSE_EN), 32'd0);
    chk("abort_ph", 32'(bus.PHASE_BIT), 32'd0);
    chk("abort_busy", 32'(bus.BUSY), 32'd0);
    chk("abort_over", 32'(bus.SIGNAL_GEN_OVER), 32'd0);
    repeat (5) @(negedge CLOCK_10M);
    chk("abort_over_later", 32'(bus.SIGNAL_GEN_OVER), 32'd0);
    run_req(32'h0000_1F35, 13, 4, 100, "restart");

    // Reset pulse mid-CHIP with GEN held high.
    set_req(32'h0000_1F35, 13, 4, 100);
    bus.GEN = 1'b1;
    repeat (10) @(negedge CLOCK_10M);
    #2 RESET = 1'b1;
    #1;
    chk("mrst_pe", 32'(bus.PULSE_EN), 32'd0);
    chk("mrst_ph", 32'(bus.PHASE_BIT), 32'd0);
    chk("mrst_over", 32'(bus.SIGNAL_GEN_OVER), 32'd0);
    chk("mrst_busy", 32'(bus.BUSY), 32'd0);
    @(negedge CLOCK_10M);
    #2 RESET = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLOCK_10M);
      chk($sformatf("mrst_norestart_busy%0d", k), 32'(bus.BUSY), 32'd0);
      chk($sformatf("mrst_norestart_pe%0d", k), 32'(bus.PULSE_EN), 32'd0);
    end
    bus.GEN = 1'b0;
    @(negedge CLOCK_10M);
    run_req(32'h0000_1F35, 13, 4, 100, "post_rst");

    // Back-to-back requests, each waiting for OVER within a cycle budget.
    for (int r = 0; r < 3; r++) begin
      set_req(32'b101, 3, 2, 20);
      bus.GEN = 1'b1;
      lat     = -1;
      over_k  = -1;
      for (int k = 1; k <= 40 && over_k < 0; k++) begin
        @(negedge CLOCK_10M);
        if (lat < 0 && bus.PULSE_EN) lat = k;
        if (k == 3 || k == 5 || k == 7)
          chk($sformatf("b2b%0d_ph_chip%0d", r, (k - 3) / 2), 32'(bus.PHASE_BIT),
              32'(b2b_ph[2 - (k - 3) / 2]));
        if (bus.SIGNAL_GEN_OVER) over_k = k;
      end
      chk($sformatf("b2b%0d_latency", r), 32'(lat), 32'd1);
      chk($sformatf("b2b%0d_over_k", r), 32'(over_k), 32'd21);
      bus.GEN = 1'b0;
      @(negedge CLOCK_10M);
      chk($sformatf("b2b%0d_over_clr", r), 32'(bus.SIGNAL_GEN_OVER), 32'd0);
    end

    // Randomized requests against the model.
    for (int r = 0; r < 20; r++) begin
      run_req($urandom, int'($urandom_range(0, 34)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 120)), $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
